// File: rtl/adder_bist_controller.sv
// BIST sequencer that sweeps every {cin,b,a} vector through a WIDTH-bit adder and checks its sum/carry.
// Optional build macro ADDER_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module adder_bist_controller #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int VW = 2*WIDTH + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] VEC_LAST    = '1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   settle;
    logic            mismatch;

    // Reference sum is formed one bit wider than the operands so the carry-out is checked too.
    function automatic logic [WIDTH:0] golden(input logic [VW-1:0] v);
        golden = {1'b0, v[WIDTH-1:0]}
               + {1'b0, v[2*WIDTH-1:WIDTH]}
               + {{WIDTH{1'b0}}, v[VW-1]};
    endfunction

    assign dut_a    = vec[WIDTH-1:0];
    assign dut_b    = vec[2*WIDTH-1:WIDTH];
    assign dut_cin  = vec[VW-1];
    assign mismatch = ({dut_cout, dut_sum} != golden(vec));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            settle    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= APPLY;
                        vec       <= '0;
                        settle    <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                APPLY: begin
                    if (settle == SETTLE_LAST) begin
                        settle <= '0;
                        state  <= CHECK;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0)
                            fail_vec <= vec;
                    end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                    if (mismatch || (vec == VEC_LAST)) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= APPLY;
                    end
`else
                    if (vec == VEC_LAST) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= APPLY;
                    end
`endif
                end
                DONE: begin
                    // err_count already holds the final CHECK's contribution here.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    vec   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_controller.sv
// Bench for adder_bist_controller: a fault-injectable adder model feeds the DUT, and a queue of
// expected sweep results (from a reference sweep model) is checked at each done pulse.
module tb_adder_bist_controller;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;
    localparam int VW     = 2*WIDTH + 1;
    localparam int NV     = 1 << VW;

    typedef struct {
        int err;
        int fvec;
        int pass;
        int lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   dut_a, dut_b, dut_sum;
    logic               dut_cin, dut_cout;
    logic               busy, done, pass;
    logic [VW:0]        err_count;
    logic [VW-1:0]      fail_vec;

    int   fault = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    adder_bist_controller #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // Adder under test: 1 = sum[0] stuck-at-0, 2 = cout stuck-at-0.
    logic [WIDTH:0] full;
    always_comb begin
        full     = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
        dut_sum  = full[WIDTH-1:0];
        dut_cout = full[WIDTH];
        if (fault == 1) dut_sum[0] = 1'b0;
        if (fault == 2) dut_cout   = 1'b0;
    end

    function automatic exp_t model(input int f);
        exp_t e;
        int a, b, c, g, s, co;
        e.err  = 0;
        e.fvec = 0;
        e.lat  = NV*(SETTLE+1) + 1;
        for (int v = 0; v < NV; v++) begin
            a  = v % (1 << WIDTH);
            b  = (v >> WIDTH) % (1 << WIDTH);
            c  = v >> (2*WIDTH);
            g  = a + b + c;
            s  = g % (1 << WIDTH);
            co = g >> WIDTH;
            if (f == 1) s  = s & ~1;
            if (f == 2) co = 0;
            if ((co*(1 << WIDTH) + s) != g) begin
                if (e.err == 0) e.fvec = v;
                e.err++;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                e.lat = (v+1)*(SETTLE+1) + 1;
                break;
`endif
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start pulse (optionally left high) and check busy in the cycle after accept.
    task automatic launch(input int f, input bit hold);
        fault = f;
        sb.push_back(model(f));
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait for done (bounded), optionally re-pulsing start mid-run, and compare to the scoreboard.
    task automatic finish_run(input bit repulse);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (done !== 1'b1 && cycles < 4*NV) begin
            step();
            cycles++;
            if (repulse && cycles == 300) start = 1'b1;
            if (repulse && cycles == 301) start = 1'b0;
        end
        e = sb.pop_front();
        check("done_latency", 32'(cycles), 32'(e.lat));
        check("err_count",    32'(err_count), 32'(e.err));
        check("fail_vec",     32'(fail_vec),  32'(e.fvec));
        check("pass",         32'(pass),      32'(e.pass));
        check("busy_at_done", 32'(busy),      32'd0);
    endtask

    initial begin
        bit saw_done;

        // Reset state
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err_count), 32'd0);
        check("rst_fvec", 32'(fail_vec), 32'd0);
        check("rst_ops",  32'({dut_cin, dut_b, dut_a}), 32'd0);
        rst_n = 1'b1;
        step();

        // Good adder
        launch(0, 1'b0);
        finish_run(1'b0);
        step();
        check("done_single_cycle", 32'(done), 32'd0);
        check("pass_held", 32'(pass), 32'd1);

        // sum[0] stuck-at-0
        launch(1, 1'b0);
        finish_run(1'b0);
        step();

        // cout stuck-at-0
        launch(2, 1'b0);
        finish_run(1'b0);
        step();

        // Reset during vector 100 aborts with no done pulse
        launch(0, 1'b0);
        void'(sb.pop_back());
        saw_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_vec", 32'({dut_cin, dut_b, dut_a}), 32'd100);
        rst_n = 1'b0;
        #1;
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err",  32'(err_count), 32'd0);
        check("abort_fvec", 32'(fail_vec), 32'd0);
        check("abort_ops",  32'({dut_cin, dut_b, dut_a}), 32'd0);
        step();
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        launch(0, 1'b0);
        finish_run(1'b0);
        step();

        // start re-pulsed while busy is ignored
        launch(0, 1'b0);
        finish_run(1'b1);
        step();

        // start held high: second run accepted right after the done cycle
        launch(1, 1'b1);
        finish_run(1'b0);
        sb.push_back(model(1));
        step();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        finish_run(1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
